// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg
// Shared definitions for the PWM/LED settings controller:
//   - fade_state_t : sequencer modes as seen on o_State
//   - PWM_DUTY_W / PWM_SHIFT_W : default duty and prescale-shift widths
//   - DUTY_MAX : largest duty value at the default duty width
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    FADE_UP   = 2'd1,
    FADE_DOWN = 2'd2
  } fade_state_t;

  localparam int PWM_DUTY_W  = 6;
  localparam int PWM_SHIFT_W = 5;

  localparam logic [PWM_DUTY_W-1:0] DUTY_MAX = {PWM_DUTY_W{1'b1}};

endpackage

// File: rtl/switch_debounce.sv
// switch_debounce
// Turns one raw (asynchronous) switch level into a single one-clock press
// event. The switch is resynchronised, then sampled only on tick; a 2-bit
// saturating count of consecutive pressed samples fires the event on the
// sample where it reaches DB_SAMPLES. A released sample clears the count.
// Ports:
//   i_Clk       in  system clock
//   i_Rst_n     in  synchronous active-low reset
//   tick        in  one-clock debounce sample strobe
//   raw_sw      in  raw switch level (1 = pressed)
//   press_event out one-clock pulse, once per press
module switch_debounce #(
  parameter int DB_SAMPLES = 2
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic tick,
  input  logic raw_sw,
  output logic press_event
);

  // Count value just before the sample that completes the press.
  localparam logic [1:0] FIRE_AT = 2'(DB_SAMPLES - 1);

  logic [1:0] sync_r;
  logic [1:0] cnt_r;
  logic       event_r;

  // Synchroniser, sample counter and registered press event.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      sync_r  <= 2'b00;
      cnt_r   <= 2'd0;
      event_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], raw_sw};
      if (tick) begin
        if (sync_r[1]) begin
          // Saturating at 3 means FIRE_AT is only ever passed once per press.
          if (cnt_r != 2'd3) begin
            cnt_r <= cnt_r + 2'd1;
          end else begin
            cnt_r <= cnt_r;
          end
          event_r <= (cnt_r == FIRE_AT);
        end else begin
          cnt_r   <= 2'd0;
          event_r <= 1'b0;
        end
      end else begin
        event_r <= 1'b0;
      end
    end
  end

  assign press_event = event_r;

endmodule

// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer
// Sequences the duty and prescale-shift settings of the PWM/LED datapath.
// Switch press events edit staging registers (manual duty up/down, shift
// advance) or toggle an automatic triangle fade; staged values are copied to
// the outputs only on i_Period_Start so a PWM period never sees a mid-period
// change.
// Ports:
//   i_Clk          in  system clock
//   i_Rst_n        in  synchronous active-low reset
//   i_Switch_1..4  in  duty up / duty down / fade toggle / shift advance
//   i_Period_Start in  one-clock pulse at PWM counter wrap
//   o_Duty         out committed duty
//   o_Shift        out committed counter shift
//   o_Update       out one-clock pulse after a commit that changed a value
//   o_State        out sequencer state (MANUAL / FADE_UP / FADE_DOWN)
module pwm_fade_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter int TICK_DIV          = 16,
  parameter int DB_SAMPLES        = 2,
  parameter int FADE_STEP_PERIODS = 4,
  parameter int DUTY_W            = PWM_DUTY_W,
  parameter int SHIFT_W           = PWM_SHIFT_W
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Switch_1,
  input  logic               i_Switch_2,
  input  logic               i_Switch_3,
  input  logic               i_Switch_4,
  input  logic               i_Period_Start,
  output logic [DUTY_W-1:0]  o_Duty,
  output logic [SHIFT_W-1:0] o_Shift,
  output logic               o_Update,
  output logic [1:0]         o_State
);

  localparam int TICK_CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STEP_CW = (FADE_STEP_PERIODS > 1) ? $clog2(FADE_STEP_PERIODS) : 1;

  localparam logic [TICK_CW-1:0] TICK_LAST = TICK_CW'(TICK_DIV - 1);
  localparam logic [STEP_CW-1:0] STEP_LAST = STEP_CW'(FADE_STEP_PERIODS - 1);
  localparam logic [STEP_CW-1:0] STEP_ONE  = STEP_CW'(1);
  localparam logic [DUTY_W-1:0]  DUTY_TOP  = {DUTY_W{1'b1}};
  localparam logic [DUTY_W-1:0]  DUTY_ONE  = DUTY_W'(1);
  localparam logic [SHIFT_W-1:0] SHIFT_ONE = SHIFT_W'(1);

  logic [TICK_CW-1:0] tick_cnt_r;
  logic               tick_r;
  logic [3:0]         raw_sw_s;
  logic [3:0]         sw_event_s;

  fade_state_t        state_r;
  logic [DUTY_W-1:0]  stg_duty_r;
  logic [SHIFT_W-1:0] stg_shift_r;
  logic [STEP_CW-1:0] step_cnt_r;

  logic [DUTY_W-1:0]  duty_r;
  logic [SHIFT_W-1:0] shift_r;
  logic               update_r;

  // Debounce sample strobe: one pulse each time the divider wraps.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      tick_cnt_r <= '0;
      tick_r     <= 1'b0;
    end else if (tick_cnt_r == TICK_LAST) begin
      tick_cnt_r <= '0;
      tick_r     <= 1'b1;
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_CW'(1);
      tick_r     <= 1'b0;
    end
  end

  assign raw_sw_s = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  for (genvar g = 0; g < 4; g++) begin : g_db
    switch_debounce #(
      .DB_SAMPLES (DB_SAMPLES)
    ) u_db (
      .i_Clk       (i_Clk),
      .i_Rst_n     (i_Rst_n),
      .tick        (tick_r),
      .raw_sw      (raw_sw_s[g]),
      .press_event (sw_event_s[g])
    );
  end

  // Mode FSM with staging registers and fade step counter.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_r     <= MANUAL;
      stg_duty_r  <= '0;
      stg_shift_r <= '0;
      step_cnt_r  <= '0;
    end else begin
      if (sw_event_s[3]) begin
        stg_shift_r <= stg_shift_r + SHIFT_ONE;
      end else begin
        stg_shift_r <= stg_shift_r;
      end

      case (state_r)
        MANUAL: begin
          // Opposing presses in the same clock cancel out.
          if (sw_event_s[0] && !sw_event_s[1]) begin
            if (stg_duty_r != DUTY_TOP) begin
              stg_duty_r <= stg_duty_r + DUTY_ONE;
            end
          end else if (sw_event_s[1] && !sw_event_s[0]) begin
            if (stg_duty_r != '0) begin
              stg_duty_r <= stg_duty_r - DUTY_ONE;
            end
          end
          if (sw_event_s[2]) begin
            state_r    <= FADE_UP;
            step_cnt_r <= '0;
          end
        end

        FADE_UP: begin
          // A mode toggle takes priority over a coincident fade step.
          if (sw_event_s[2]) begin
            state_r    <= MANUAL;
            step_cnt_r <= '0;
          end else if (i_Period_Start) begin
            if (step_cnt_r == STEP_LAST) begin
              step_cnt_r <= '0;
              if (stg_duty_r == DUTY_TOP) begin
                state_r <= FADE_DOWN;
              end else begin
                stg_duty_r <= stg_duty_r + DUTY_ONE;
                if ((stg_duty_r + DUTY_ONE) == DUTY_TOP) begin
                  state_r <= FADE_DOWN;
                end
              end
            end else begin
              step_cnt_r <= step_cnt_r + STEP_ONE;
            end
          end
        end

        FADE_DOWN: begin
          if (sw_event_s[2]) begin
            state_r    <= MANUAL;
            step_cnt_r <= '0;
          end else if (i_Period_Start) begin
            if (step_cnt_r == STEP_LAST) begin
              step_cnt_r <= '0;
              if (stg_duty_r == '0) begin
                state_r <= FADE_UP;
              end else begin
                stg_duty_r <= stg_duty_r - DUTY_ONE;
                if (stg_duty_r == DUTY_ONE) begin
                  state_r <= FADE_UP;
                end
              end
            end else begin
              step_cnt_r <= step_cnt_r + STEP_ONE;
            end
          end
        end

        default: begin
          state_r    <= MANUAL;
          step_cnt_r <= '0;
        end
      endcase
    end
  end

  // Period-boundary commit of staged settings plus change pulse.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      duty_r   <= '0;
      shift_r  <= '0;
      update_r <= 1'b0;
    end else if (i_Period_Start) begin
      duty_r   <= stg_duty_r;
      shift_r  <= stg_shift_r;
      update_r <= (stg_duty_r != duty_r) || (stg_shift_r != shift_r);
    end else begin
      duty_r   <= duty_r;
      shift_r  <= shift_r;
      update_r <= 1'b0;
    end
  end

  assign o_Duty   = duty_r;
  assign o_Shift  = shift_r;
  assign o_Update = update_r;
  assign o_State  = state_r;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// tb_pwm_fade_sequencer
// Directed bench for pwm_fade_sequencer with TICK_DIV=4, DB_SAMPLES=2,
// FADE_STEP_PERIODS=2 and a period start every 64 clocks. Inputs change
// and outputs are sampled on the falling clock edge.
module tb_pwm_fade_sequencer;
  import pwm_ctrl_pkg::*;

  logic       i_Clk = 1'b0;
  logic       i_Rst_n;
  logic       i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4;
  logic       i_Period_Start;
  logic [5:0] o_Duty;
  logic [4:0] o_Shift;
  logic       o_Update;
  logic [1:0] o_State;

  int tests = 0;
  int fails = 0;
  int pcnt  = 0;

  pwm_fade_sequencer #(
    .TICK_DIV          (4),
    .DB_SAMPLES        (2),
    .FADE_STEP_PERIODS (2),
    .DUTY_W            (6),
    .SHIFT_W           (5)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Rst_n        (i_Rst_n),
    .i_Switch_1     (i_Switch_1),
    .i_Switch_2     (i_Switch_2),
    .i_Switch_3     (i_Switch_3),
    .i_Switch_4     (i_Switch_4),
    .i_Period_Start (i_Period_Start),
    .o_Duty         (o_Duty),
    .o_Shift        (o_Shift),
    .o_Update       (o_Update),
    .o_State        (o_State)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    tests++;
    fails++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  // One clock: advance to the falling edge, drive the period pulse.
  task automatic cyc();
    @(negedge i_Clk);
    pcnt = pcnt + 1;
    i_Period_Start = ((pcnt % 64) == 63);
  endtask

  // Run through the next period-start edge; return one clock after it.
  task automatic run_to_commit();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      cyc();
      if (i_Period_Start) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) bound_fail("period_wait");
    cyc();
  endtask

  // Hold the switches in mask (bit0 = SW1) for 4 ticks, then release.
  task automatic press(input logic [3:0] m);
    {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1} = m;
    repeat (16) cyc();
    {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1} = 4'b0000;
    repeat (16) cyc();
  endtask

  initial begin
    logic found;
    i_Rst_n = 1'b0;
    {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1} = 4'b0000;
    i_Period_Start = 1'b0;
    repeat (3) cyc();
    chk("rst_duty", o_Duty, 0);
    chk("rst_shift", o_Shift, 0);
    chk("rst_update", o_Update, 0);
    chk("rst_state", o_State, MANUAL);
    i_Rst_n = 1'b1;

    // First press after reset: one event, duty 0 -> 1, single update pulse.
    press(4'b0001);
    chk("pre_commit_duty", o_Duty, 0);
    run_to_commit();
    chk("first_duty", o_Duty, 1);
    chk("first_update", o_Update, 1);
    cyc();
    chk("first_update_drop", o_Update, 0);

    // Manual climb to the top, one press per period.
    for (int k = 2; k <= 63; k++) begin
      press(4'b0001);
      run_to_commit();
      chk("climb_duty", o_Duty, k);
    end
    chk("climb_update", o_Update, 1);

    // Saturation at max.
    press(4'b0001);
    run_to_commit();
    chk("sat_hi_duty", o_Duty, DUTY_MAX);
    chk("sat_hi_update", o_Update, 0);

    // SW1 and SW2 together cancel.
    press(4'b0011);
    run_to_commit();
    chk("both_duty", o_Duty, 63);
    chk("both_update", o_Update, 0);

    press(4'b0010);
    run_to_commit();
    chk("down_duty", o_Duty, 62);

    // Fade from 62: up to 63 after two periods, then down to 0.
    press(4'b0100);
    run_to_commit();
    chk("fade_state_up", o_State, FADE_UP);
    chk("fade_p1_duty", o_Duty, 62);
    for (int m = 1; m <= 64; m++) begin
      run_to_commit();
      run_to_commit();
      chk("fade_duty", o_Duty, 64 - m);
      chk("fade_state", o_State, (m == 64) ? FADE_UP : FADE_DOWN);
    end

    // Toggle back to manual: duty frozen at 0.
    press(4'b0100);
    run_to_commit();
    chk("manual_state", o_State, MANUAL);
    chk("manual_duty", o_Duty, 0);
    chk("manual_update", o_Update, 0);
    run_to_commit();
    chk("frozen_duty", o_Duty, 0);

    // Saturation at zero.
    press(4'b0010);
    run_to_commit();
    chk("sat_lo_duty", o_Duty, 0);
    chk("sat_lo_update", o_Update, 0);

    // Shift advances only at period starts and wraps after 32 presses.
    for (int k = 1; k <= 32; k++) begin
      press(4'b1000);
      chk("shift_hold", o_Shift, (k - 1) % 32);
      run_to_commit();
      chk("shift_val", o_Shift, k % 32);
      chk("shift_update", o_Update, 1);
    end

    press(4'b1000);
    run_to_commit();
    chk("shift_one", o_Shift, 1);

    // Start a fade from 0 and wait for duty 40 on the way down.
    press(4'b0100);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      run_to_commit();
      if (o_State == FADE_DOWN && o_Duty == 6'd40) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) bound_fail("reach_40_down");
    chk("mid_fade_duty", o_Duty, 40);

    // Reset on the same edge as a period start.
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      cyc();
      if (i_Period_Start) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) bound_fail("period_wait_rst");
    i_Rst_n = 1'b0;
    cyc();
    i_Rst_n = 1'b1;
    chk("midrst_duty", o_Duty, 0);
    chk("midrst_shift", o_Shift, 0);
    chk("midrst_update", o_Update, 0);
    chk("midrst_state", o_State, MANUAL);
    run_to_commit();
    chk("postrst_duty", o_Duty, 0);
    chk("postrst_shift", o_Shift, 0);
    chk("postrst_update", o_Update, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_fade_sequencer.md
# pwm_fade_sequencer

Controller that sequences the settings of the board's PWM/LED datapath. It debounces the four user switches and runs a manual/auto-fade state machine that produces a 6-bit duty value and a 5-bit counter shift (prescale). Settings are committed to the datapath only on PWM period boundaries so the output never glitches. It sits between the switch pins and the free-running PWM counter/comparator.

## Interface
- TICK_DIV, 16: clocks per debounce sample tick.
- DB_SAMPLES, 2: consecutive pressed samples that fire one press event (1..3).
- FADE_STEP_PERIODS, 4: PWM periods per fade step (≥1).
- DUTY_W, 6: duty width.
- SHIFT_W, 5: shift width.
- Ports:
  - i_Clk  in  1  system clock.
  - i_Rst_n  in  1  reset, synchronous and active-low.
  - i_Switch_1  in  1  duty up.
  - i_Switch_2  in  1  duty down.
  - i_Switch_3  in  1  fade mode toggle.
  - i_Switch_4  in  1  shift advance.
  - i_Period_Start  in  1  one-clock pulse from datapath at PWM counter wrap.
  - o_Duty  out  DUTY_W  committed duty.
  - o_Shift  out  SHIFT_W  committed shift.
  - o_Update  out  1  one-clock pulse: committed values changed.
  - o_State  out  2  FSM state.

## Operation
- Tick: counter 0..TICK_DIV-1. Tick pulse when the counter wraps to 0.
- Debounce, per switch, updated on tick only:
  - 2-bit count saturates at 3 while pressed, cleared when released.
  - A press event (one clock) fires on the tick where the count becomes DB_SAMPLES. Exactly one event per press.
- Staging registers: stg_duty and stg_shift. Events modify staging, never the outputs directly.
- FSM states: MANUAL=0, FADE_UP=1, FADE_DOWN=2 (3 unused, recovers to MANUAL).
  - MANUAL:
    - SW1 event: stg_duty+1, saturating at 2^DUTY_W-1.
    - SW2 event: stg_duty-1, saturating at 0.
    - SW1 and SW2 events in the same clock: no change.
    - SW3 event: go to FADE_UP.
  - FADE_UP/FADE_DOWN:
    - SW1/SW2 events ignored.
    - Step counter counts i_Period_Start pulses. Every FADE_STEP_PERIODS-th pulse, stg_duty ±1 and the step counter clears.
    - FADE_UP reaching max: switch to FADE_DOWN at the same edge.
    - FADE_DOWN reaching 0: switch to FADE_UP.
    - SW3 event: go to MANUAL. stg_duty is kept and the step counter clears.
  - SW4 event, any state: stg_shift+1, wrapping mod 2^SHIFT_W.
- Commit: on i_Period_Start, o_Duty<=stg_duty and o_Shift<=stg_shift. The commit uses pre-edge staging values.
- o_Update: asserted the clock after a commit in which either committed value changed.

## Timing
- Reset (i_Rst_n=0 at an edge) clears everything to the following values:
  - o_Duty=0, o_Shift=0, o_Update=0, o_State=MANUAL.
  - Staging, debounce counts, tick counter and step counter all 0.
- Reset mid-fade or mid-press: same reset values at the next edge. i_Period_Start is ignored while in reset.
- A press is not required to be released across reset.
- Press-to-event latency: DB_SAMPLES ticks, ±1 tick of phase.
- Event-to-output latency: the next i_Period_Start after the event edge, plus 1 clock.
- Event and i_Period_Start in the same clock: the new value commits at the following period start.
- Fade step and commit on the same i_Period_Start: the commit takes the old stg_duty, so one period of lag.
- SW3 event on the same edge as a fade step: the mode change wins and no step is applied.

## Structure
- Package pwm_ctrl_pkg holds:
  - state enum (MANUAL, FADE_UP, FADE_DOWN);
  - default width constants DUTY_W=6 and SHIFT_W=5;
  - DUTY_MAX.
- Sub-module switch_debounce (inputs: tick, raw switch; output: event), instantiated four times.
- FSM, staging and commit logic live in the top.

## Test plan
Bench uses TICK_DIV=4, DB_SAMPLES=2, FADE_STEP_PERIODS=2, and i_Period_Start every 64 clocks.

- Reset release:
  - Stimulus: hold SW1 4 ticks, then release.
  - Required: one event; o_Duty 0→1 at the next period start; o_Update pulses once.
- Saturation:
  - Stimulus: from duty 63, SW1 press; from duty 0, SW2 press.
  - Required: duty stays 63, then stays 0; no o_Update.
- Simultaneous SW1+SW2:
  - Stimulus: press both with identical timing.
  - Required: duty unchanged.
- Fade:
  - Stimulus: SW3 press from duty 62.
  - Required: o_State=1, then 63 two periods later, then o_State=2, then 62…0, then o_State=1.
  - Stimulus: SW3 again.
  - Required: MANUAL, duty frozen.
- Shift wrap:
  - Stimulus: 32 SW4 presses.
  - Required: o_Shift returns to 0; each change commits only at a period start.
- Reset mid-fade:
  - Stimulus: assert i_Rst_n=0 for 1 clock during FADE_DOWN at duty 40.
  - Required: all outputs 0 and state MANUAL next edge; no commit on a coincident i_Period_Start.
